obi_data_arbiter: RTL and testbench

Two-master OBI data-port arbiter placed directly downstream of the vector load/store unit. It merges the scalar core's data port and the VLSU's data port onto the single OBI data port of the shared memory. It tracks outstanding transactions in a small in-order route FIFO, so each response is returned to the master that issued the request. The arbiter adds no latency on the address or response path.

---
 rtl/obi_data_arbiter.sv | 173 +++++++++++++++++
 tb/tb_obi_data_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_data_arbiter.sv
// Two-master OBI data-port arbiter: merges the scalar core and VLSU data ports
// onto one memory port. An in-order route FIFO remembers which master issued each
// granted request so every response returns to its issuer. All paths are
// combinational; only the lock, the round-robin pointer, the FIFO and the error
// flag are registered.
module obi_data_arbiter #(
  parameter int MAX_OUTSTANDING   = 2,
  parameter bit RESET_FAVOUR_VLSU = 1'b1
) (
  input  logic        clk,
  input  logic        n_reset,
  // scalar core master
  input  logic        core_req_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic [31:0] core_rdata_o,
  // VLSU master
  input  logic        vlsu_req_i,
  output logic        vlsu_gnt_o,
  output logic        vlsu_rvalid_o,
  input  logic [31:0] vlsu_addr_i,
  input  logic        vlsu_we_i,
  input  logic [3:0]  vlsu_be_i,
  input  logic [31:0] vlsu_wdata_i,
  output logic [31:0] vlsu_rdata_o,
  // memory port
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  // status
  output logic        busy_o,
  output logic        resp_err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic SRC_CORE = 1'b0;
  localparam logic SRC_VLSU = 1'b1;

  logic             rr_ptr;      // master that wins the next tie
  logic             lock;        // address phase in progress, source frozen
  logic             lock_src;
  logic             resp_err;
  logic             route [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic sel_valid;
  logic sel_src;
  logic sel_req;
  logic empty;
  logic full;
  logic push;
  logic pop;
  logic head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Source selection: a pending address phase keeps its source, otherwise
  // a lone requester wins and a tie goes to the round-robin pointer.
  always_comb begin
    sel_valid = 1'b0;
    sel_src   = rr_ptr;
    if (lock) begin
      sel_valid = 1'b1;
      sel_src   = lock_src;
    end else if (core_req_i && vlsu_req_i) begin
      sel_valid = 1'b1;
      sel_src   = rr_ptr;
    end else if (core_req_i) begin
      sel_valid = 1'b1;
      sel_src   = SRC_CORE;
    end else if (vlsu_req_i) begin
      sel_valid = 1'b1;
      sel_src   = SRC_VLSU;
    end
  end

  // A response arriving this cycle frees a slot, so a full FIFO can still
  // accept a new request in the same cycle.
  assign empty   = (count == '0);
  assign pop     = mem_rvalid_i & ~empty;
  assign full    = (count == CNT_W'(MAX_OUTSTANDING)) & ~pop;
  assign sel_req = sel_valid & ((sel_src == SRC_VLSU) ? vlsu_req_i : core_req_i);
  assign head    = route[rd_ptr];

  assign mem_req_o  = sel_req & ~full;
  assign push       = mem_req_o & mem_gnt_i;
  assign core_gnt_o = push & (sel_src == SRC_CORE);
  assign vlsu_gnt_o = push & (sel_src == SRC_VLSU);

  // Address-phase mux; idle outputs are forced to zero.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (sel_valid) begin
      if (sel_src == SRC_VLSU) begin
        mem_addr_o  = vlsu_addr_i;
        mem_we_o    = vlsu_we_i;
        mem_be_o    = vlsu_be_i;
        mem_wdata_o = vlsu_wdata_i;
      end else begin
        mem_addr_o  = core_addr_i;
        mem_we_o    = core_we_i;
        mem_be_o    = core_be_i;
        mem_wdata_o = core_wdata_i;
      end
    end
  end

  assign core_rvalid_o = pop & (head == SRC_CORE);
  assign vlsu_rvalid_o = pop & (head == SRC_VLSU);
  assign core_rdata_o  = mem_rdata_i;
  assign vlsu_rdata_o  = mem_rdata_i;
  assign busy_o        = ~empty;
  assign resp_err_o    = resp_err;

  // Arbitration state: lock, round-robin pointer and the sticky error flag.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      lock     <= 1'b0;
      lock_src <= SRC_CORE;
      rr_ptr   <= RESET_FAVOUR_VLSU;
      resp_err <= 1'b0;
    end else begin
      if (push) begin
        lock   <= 1'b0;
        rr_ptr <= ~sel_src;
      end else if (mem_req_o) begin
        lock     <= 1'b1;
        lock_src <= sel_src;
      end
      if (mem_rvalid_i && empty) resp_err <= 1'b1;
    end
  end

  // Route FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Route FIFO storage: source ID of each accepted request.
  always_ff @(posedge clk) begin
    if (push) route[wr_ptr] <= sel_src;
  end

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Testbench for obi_data_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_obi_data_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        core_req_i, core_gnt_o, core_rvalid_o, core_we_i;
  logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
  logic [3:0]  core_be_i;
  logic        vlsu_req_i, vlsu_gnt_o, vlsu_rvalid_o, vlsu_we_i;
  logic [31:0] vlsu_addr_i, vlsu_wdata_i, vlsu_rdata_o;
  logic [3:0]  vlsu_be_i;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  logic        busy_o, resp_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_data_arbiter #(.MAX_OUTSTANDING(MAXO), .RESET_FAVOUR_VLSU(1'b1)) dut (
    .clk(clk), .n_reset(n_reset),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .core_addr_i(core_addr_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o),
    .vlsu_req_i(vlsu_req_i), .vlsu_gnt_o(vlsu_gnt_o), .vlsu_rvalid_o(vlsu_rvalid_o),
    .vlsu_addr_i(vlsu_addr_i), .vlsu_we_i(vlsu_we_i), .vlsu_be_i(vlsu_be_i),
    .vlsu_wdata_i(vlsu_wdata_i), .vlsu_rdata_o(vlsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .resp_err_o(resp_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req_i = 0; core_addr_i = '0; core_we_i = 0; core_be_i = '0; core_wdata_i = '0;
    vlsu_req_i = 0; vlsu_addr_i = '0; vlsu_we_i = 0; vlsu_be_i = '0; vlsu_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    n_reset = 0;
    idle();
    tick();
    tick();
    n_reset = 1;
  endtask

  task automatic test_reset();
    n_reset = 0;
    idle();
    tick();
    tick();
    #1;
    checks++;
    if ({mem_req_o, core_gnt_o, vlsu_gnt_o, core_rvalid_o, vlsu_rvalid_o, busy_o, resp_err_o, mem_we_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {mem_req_o, core_gnt_o, vlsu_gnt_o, core_rvalid_o, vlsu_rvalid_o, busy_o, resp_err_o, mem_we_o});
    end
    checks++;
    if ({mem_addr_o, mem_wdata_o, mem_be_o} !== 68'h0) begin
      errors++;
      $display("FAIL reset_data: addr %h wdata %h be %h want all zero", mem_addr_o, mem_wdata_o, mem_be_o);
    end
    n_reset = 1;
    tick();
  endtask

  task automatic test_single_vlsu();
    do_reset();
    vlsu_req_i = 1; vlsu_addr_i = 32'h100; mem_gnt_i = 1;
    #1;
    checks++;
    if (vlsu_gnt_o !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b want 1", vlsu_gnt_o); end
    checks++;
    if (mem_addr_o !== 32'h100) begin errors++; $display("FAIL single_addr: got %h want 00000100", mem_addr_o); end
    checks++;
    if (core_rvalid_o !== 1'b0) begin errors++; $display("FAIL single_core_rvalid0: got %b want 0", core_rvalid_o); end
    tick();
    vlsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    #1;
    checks++;
    if (vlsu_rvalid_o !== 1'b1) begin errors++; $display("FAIL single_rvalid: got %b want 1", vlsu_rvalid_o); end
    checks++;
    if (vlsu_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", vlsu_rdata_o); end
    checks++;
    if (core_rvalid_o !== 1'b0) begin errors++; $display("FAIL single_core_rvalid1: got %b want 0", core_rvalid_o); end
    tick();
    idle();
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_tie();
    int exp_src [4] = '{1, 0, 1, 0};
    do_reset();
    core_addr_i = 32'h200; vlsu_addr_i = 32'h300;
    for (int k = 0; k < 5; k++) begin
      core_req_i = (k < 4); vlsu_req_i = (k < 4); mem_gnt_i = (k < 4);
      mem_rvalid_i = (k > 0); mem_rdata_i = 32'h1000 + k;
      #1;
      if (k < 4) begin
        checks++;
        if (vlsu_gnt_o !== (exp_src[k] == 1) || core_gnt_o !== (exp_src[k] == 0)) begin
          errors++;
          $display("FAIL tie_gnt[%0d]: core %b vlsu %b want vlsu=%0d", k, core_gnt_o, vlsu_gnt_o, exp_src[k]);
        end
        checks++;
        if (mem_addr_o !== ((exp_src[k] == 1) ? 32'h300 : 32'h200)) begin
          errors++;
          $display("FAIL tie_addr[%0d]: got %h want src %0d", k, mem_addr_o, exp_src[k]);
        end
      end
      if (k > 0) begin
        checks++;
        if (vlsu_rvalid_o !== (exp_src[k-1] == 1) || core_rvalid_o !== (exp_src[k-1] == 0)) begin
          errors++;
          $display("FAIL tie_rvalid[%0d]: core %b vlsu %b want vlsu=%0d", k, core_rvalid_o, vlsu_rvalid_o, exp_src[k-1]);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    core_req_i = 1; core_addr_i = 32'h40; mem_gnt_i = 0;
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40 || core_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL lock_c1: req %b addr %h gnt %b want 1 00000040 0", mem_req_o, mem_addr_o, core_gnt_o);
    end
    tick();
    vlsu_req_i = 1; vlsu_addr_i = 32'h80;
    for (int c = 2; c <= 3; c++) begin
      #1;
      checks++;
      if (mem_addr_o !== 32'h40 || vlsu_gnt_o !== 1'b0 || core_gnt_o !== 1'b0) begin
        errors++;
        $display("FAIL lock_hold_c%0d: addr %h vgnt %b cgnt %b want 00000040 0 0", c, mem_addr_o, vlsu_gnt_o, core_gnt_o);
      end
      tick();
    end
    mem_gnt_i = 1;
    #1;
    checks++;
    if (core_gnt_o !== 1'b1 || vlsu_gnt_o !== 1'b0 || mem_addr_o !== 32'h40) begin
      errors++;
      $display("FAIL lock_grant: cgnt %b vgnt %b addr %h want 1 0 00000040", core_gnt_o, vlsu_gnt_o, mem_addr_o);
    end
    tick();
    core_req_i = 0; mem_rvalid_i = 1;
    #1;
    checks++;
    if (vlsu_gnt_o !== 1'b1 || mem_addr_o !== 32'h80) begin
      errors++;
      $display("FAIL lock_next_vlsu: vgnt %b addr %h want 1 00000080", vlsu_gnt_o, mem_addr_o);
    end
    checks++;
    if (core_rvalid_o !== 1'b1) begin errors++; $display("FAIL lock_core_rvalid: got %b want 1", core_rvalid_o); end
    tick();
    vlsu_req_i = 0; mem_gnt_i = 0;
    #1;
    checks++;
    if (vlsu_rvalid_o !== 1'b1) begin errors++; $display("FAIL lock_vlsu_rvalid: got %b want 1", vlsu_rvalid_o); end
    tick();
    idle();
  endtask

  task automatic test_fifo_full();
    do_reset();
    core_req_i = 1; mem_gnt_i = 1;
    for (int c = 0; c < 2; c++) begin
      core_addr_i = 32'h10 + 4 * c;
      #1;
      checks++;
      if (core_gnt_o !== 1'b1) begin errors++; $display("FAIL full_fill%0d: gnt %b want 1", c, core_gnt_o); end
      tick();
    end
    core_addr_i = 32'h18;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || core_gnt_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL full_stall: req %b gnt %b busy %b want 0 0 1", mem_req_o, core_gnt_o, busy_o);
    end
    tick();
    mem_rvalid_i = 1;
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || core_gnt_o !== 1'b1 || core_rvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL full_pushpop: req %b gnt %b rvalid %b want 1 1 1", mem_req_o, core_gnt_o, core_rvalid_o);
    end
    tick();
    mem_rvalid_i = 0; core_addr_i = 32'h1C;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL full_after_pushpop: req %b busy %b want 0 1", mem_req_o, busy_o);
    end
    tick();
    core_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    tick();
    tick();
    mem_rvalid_i = 0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || resp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: busy %b err %b want 0 0", busy_o, resp_err_o);
    end
    idle();
  endtask

  task automatic test_spurious();
    do_reset();
    mem_rvalid_i = 1; mem_rdata_i = 32'h12345678;
    #1;
    checks++;
    if (core_rvalid_o !== 1'b0 || vlsu_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL spur_rvalid: core %b vlsu %b want 0 0", core_rvalid_o, vlsu_rvalid_o);
    end
    tick();
    mem_rvalid_i = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (resp_err_o !== 1'b1) begin errors++; $display("FAIL spur_err%0d: got %b want 1", c, resp_err_o); end
      tick();
    end
    n_reset = 0;
    tick();
    n_reset = 1;
    #1;
    checks++;
    if (resp_err_o !== 1'b0) begin errors++; $display("FAIL spur_reset_clear: got %b want 0", resp_err_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    vlsu_req_i = 1; mem_gnt_i = 1; vlsu_addr_i = 32'h500;
    tick();
    tick();
    #1;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy_o); end
    n_reset = 0;
    idle();
    tick();
    n_reset = 1;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b want 0", busy_o); end
    mem_rvalid_i = 1;
    #1;
    checks++;
    if (vlsu_rvalid_o !== 1'b0 || core_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_rvalid: core %b vlsu %b want 0 0", core_rvalid_o, vlsu_rvalid_o);
    end
    tick();
    mem_rvalid_i = 0;
    core_req_i = 1; vlsu_req_i = 1; mem_gnt_i = 1;
    #1;
    checks++;
    if (resp_err_o !== 1'b1) begin errors++; $display("FAIL mid_err: got %b want 1", resp_err_o); end
    checks++;
    if (vlsu_gnt_o !== 1'b1 || core_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_ptr_vlsu: vgnt %b cgnt %b want 1 0", vlsu_gnt_o, core_gnt_o);
    end
    tick();
    idle();
  endtask

  // Randomized traffic checked against a transaction-level model: each master
  // holds one pending request until granted, a queue holds issuers of
  // outstanding transactions in order, ties alternate after every transfer.
  task automatic test_random();
    bit          pend [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata [2];
    logic        p_we [2];
    logic [3:0]  p_be [2];
    int          q [$];
    int          tie;
    int          locked;
    int          winner;
    bit          rv, fullm, e_req;
    do_reset();
    tie = 1; locked = -1; pend[0] = 0; pend[1] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 99) < 60) begin
          pend[m] = 1; p_addr[m] = $urandom; p_wdata[m] = $urandom;
          p_we[m] = 1'($urandom_range(0, 1)); p_be[m] = 4'($urandom_range(0, 15));
        end
      end
      core_req_i = pend[0]; core_addr_i = p_addr[0]; core_wdata_i = p_wdata[0];
      core_we_i = p_we[0]; core_be_i = p_be[0];
      vlsu_req_i = pend[1]; vlsu_addr_i = p_addr[1]; vlsu_wdata_i = p_wdata[1];
      vlsu_we_i = p_we[1]; vlsu_be_i = p_be[1];
      mem_gnt_i = ($urandom_range(0, 99) < 65);
      rv = (q.size() > 0) && ($urandom_range(0, 99) < 55);
      mem_rvalid_i = rv; mem_rdata_i = $urandom;
      #1;
      if (locked >= 0) winner = locked;
      else if (pend[0] && pend[1]) winner = tie;
      else if (pend[0]) winner = 0;
      else if (pend[1]) winner = 1;
      else winner = -1;
      fullm = (q.size() == MAXO) && !rv;
      e_req = (winner >= 0) && !fullm;
      checks++;
      if (mem_req_o !== e_req) begin errors++; $display("FAIL rnd_req[%0d]: got %b want %b", cyc, mem_req_o, e_req); end
      checks++;
      if (core_gnt_o !== (e_req && mem_gnt_i && winner == 0) || vlsu_gnt_o !== (e_req && mem_gnt_i && winner == 1)) begin
        errors++;
        $display("FAIL rnd_gnt[%0d]: core %b vlsu %b want winner %0d req %b gnt %b", cyc, core_gnt_o, vlsu_gnt_o, winner, e_req, mem_gnt_i);
      end
      if (e_req) begin
        checks++;
        if (mem_addr_o !== p_addr[winner] || mem_wdata_o !== p_wdata[winner] || mem_we_o !== p_we[winner] || mem_be_o !== p_be[winner]) begin
          errors++;
          $display("FAIL rnd_addr[%0d]: addr %h wdata %h want %h %h", cyc, mem_addr_o, mem_wdata_o, p_addr[winner], p_wdata[winner]);
        end
      end
      checks++;
      if (core_rvalid_o !== (rv && q[0] == 0) || vlsu_rvalid_o !== (rv && q[0] == 1)) begin
        errors++;
        $display("FAIL rnd_rvalid[%0d]: core %b vlsu %b want rv %b to %0d", cyc, core_rvalid_o, vlsu_rvalid_o, rv, rv ? q[0] : -1);
      end
      checks++;
      if (core_rdata_o !== mem_rdata_i || vlsu_rdata_o !== mem_rdata_i) begin
        errors++;
        $display("FAIL rnd_rdata[%0d]: core %h vlsu %h want %h", cyc, core_rdata_o, vlsu_rdata_o, mem_rdata_i);
      end
      checks++;
      if (busy_o !== (q.size() > 0) || resp_err_o !== 1'b0) begin
        errors++;
        $display("FAIL rnd_status[%0d]: busy %b err %b want %b 0", cyc, busy_o, resp_err_o, q.size() > 0);
      end
      if (rv) void'(q.pop_front());
      if (e_req && mem_gnt_i) begin
        q.push_back(winner);
        tie = 1 - winner;
        locked = -1;
        pend[winner] = 0;
      end else if (e_req) begin
        locked = winner;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    n_reset = 0;
    idle();
    test_reset();
    test_single_vlsu();
    test_tie();
    test_lock();
    test_fifo_full();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
